fifo_burst_reader: RTL
======================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameters SHALL be: DDR_DATA_W, 64, beat width; BURST_LEN, 8, beats per burst (power of 2, 2..16); STALL_MAX, 15, stall cycles before underrun flag.
REQ-002 Ports SHALL be (name direction width meaning):
- clk_i  in  1  single clock
- rst  in  1  reset (synchronous, active-high)
- burst_req_i  in  1  downstream requests one burst
- burst_gnt_o  out  1  one-cycle pulse, request accepted
- fifo_rd_ready_i  in  1  FIFO has a beat; data valid same cycle
- fifo_data_i  in  DDR_DATA_W  FIFO read data (combinational)
- fifo_rd_o  out  1  pop strobe
- dq_valid_o  out  1  output beat valid
- dq_data_o  out  DDR_DATA_W  output beat
- dq_last_o  out  1  final beat of burst
- dq_ready_i  in  1  downstream accepts beat
- busy_o  out  1  state != IDLE
- underrun_o  out  1  one-cycle pulse, stall limit hit
- burst_cnt_o  out  16  completed bursts, wraps
REQ-003 Clock is one clock; reset is synchronous and active-high; ports SHALL be named clk_i and rst.

Function
REQ-004 fifo_rd_o SHALL be combinational: fifo_rd_ready_i & state==BURST & pop_cnt<BURST_LEN & buffer not full; it SHALL never assert while fifo_rd_ready_i is low.
REQ-005 A popped beat SHALL be written into a 2-entry output buffer in the same cycle fifo_rd_o is high; no beat may be dropped or duplicated.
REQ-006 dq_valid_o SHALL equal buffer non-empty; dq_data_o SHALL be the head entry; a beat leaves on dq_valid_o & dq_ready_i.
REQ-007 Simultaneous push and pop on the buffer SHALL keep occupancy constant; full-buffer push SHALL be blocked by REQ-004, giving 1 beat/cycle sustained throughput.
REQ-008 dq_last_o SHALL be high only with dq_valid_o on the beat where out_cnt==BURST_LEN-1.
REQ-009 States SHALL be IDLE, BURST, FLUSH.
- IDLE: burst_req_i -> burst_gnt_o=1, clear pop_cnt/out_cnt/stall_cnt, -> BURST.
- BURST: pop per REQ-004; when pop_cnt reaches BURST_LEN -> FLUSH.
- FLUSH: no pops; on accepted last beat -> IDLE, burst_cnt_o +1 (wraps 0xFFFF->0).
REQ-010 burst_req_i SHALL be ignored outside IDLE; a new grant SHALL occur no earlier than the cycle after return to IDLE (request-to-request minimum BURST_LEN+2 cycles).
REQ-011 Latency: grant in cycle N with FIFO ready -> first pop N+1, first dq_valid_o N+2.
REQ-012 In BURST, stall_cnt SHALL increment each cycle fifo_rd_ready_i=0 and pop_cnt<BURST_LEN, clear on any pop; on reaching STALL_MAX, underrun_o pulses once and stall_cnt clears; the burst SHALL continue waiting (no abort).
REQ-013 Downstream backpressure (dq_ready_i=0) SHALL never trigger underrun_o.
REQ-014 pop_cnt and out_cnt SHALL be $clog2(BURST_LEN)+1 bits; no counter may wrap within a burst.

Reset
REQ-015 While rst=1 at a clk_i edge: state=IDLE, buffer empty, all counters 0; outputs dq_valid_o, dq_last_o, burst_gnt_o, underrun_o, busy_o, fifo_rd_o =0, burst_cnt_o=0, dq_data_o=0.
REQ-016 Reset mid-burst SHALL discard buffered beats, assert no pop in the reset cycle, and require a new burst_req_i.

Structure
REQ-017 DDR_DATA_W, BURST_LEN default and state encoding (2-bit: IDLE=0, BURST=1, FLUSH=2) SHALL live in the shared controller package.
REQ-018 The 2-entry output buffer SHALL be a sub-module named skid_buf2 (push/pop/full/empty, synchronous active-high reset).

Verification
REQ-019 FIFO always ready, dq_ready_i=1, one request -> grant at N, 8 beats on dq N+2..N+9 in FIFO order, dq_last_o at N+9, burst_cnt_o=1.
REQ-020 dq_ready_i toggling 1/0 -> exactly 8 beats, order kept, buffer occupancy never >2, fifo_rd_o low when full.
REQ-021 FIFO empty after 3 beats for 20 cycles -> underrun_o pulses at stall 15, burst completes with 8 beats when data resumes.
REQ-022 burst_req_i held high continuously -> grants spaced >=10 cycles, no overlap, burst_cnt_o counts each burst.
REQ-023 rst asserted after 4 beats -> next cycle all outputs at reset values, no further pops until new grant.
REQ-024 burst_cnt_o preset by 65535 bursts -> next completion wraps to 0.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: default geometry, FSM encoding
// and a counter-width helper.
package fifo_burst_reader_pkg;

  localparam int unsigned DDR_DATA_W_DEF = 64;
  localparam int unsigned BURST_LEN_DEF  = 8;
  localparam int unsigned STALL_MAX_DEF  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Beat counters must hold the value BURST_LEN itself without wrapping.
  function automatic int unsigned beat_cnt_w(input int unsigned len);
    return $clog2(len) + 1;
  endfunction

endpackage

// File: rtl/fifo_burst_reader_skid_buf2.sv
// Two-entry output buffer: push/pop in the same cycle keeps occupancy constant.
module skid_buf2 #(
  parameter int unsigned W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads fixed-length bursts from a show-ahead FIFO into a 2-entry output buffer,
// flags FIFO starvation and counts completed bursts.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DDR_DATA_W = DDR_DATA_W_DEF,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
  parameter int unsigned STALL_MAX  = STALL_MAX_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  burst_req_i,
  output logic                  burst_gnt_o,
  input  logic                  fifo_rd_ready_i,
  input  logic [DDR_DATA_W-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
  output logic                  dq_valid_o,
  output logic [DDR_DATA_W-1:0] dq_data_o,
  output logic                  dq_last_o,
  input  logic                  dq_ready_i,
  output logic                  busy_o,
  output logic                  underrun_o,
  output logic [15:0]           burst_cnt_o
);

  localparam int unsigned CW = beat_cnt_w(BURST_LEN);
  localparam int unsigned SW = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] LEN        = CW'(BURST_LEN);
  localparam logic [CW-1:0] LAST       = CW'(BURST_LEN - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

  state_e        r_state;
  logic [CW-1:0] r_pop_cnt;
  logic [CW-1:0] r_out_cnt;
  logic [SW-1:0] r_stall_cnt;
  logic          r_underrun;
  logic [15:0]   r_burst_cnt;

  logic w_full;
  logic w_empty;
  logic w_pop_fifo;
  logic w_accept;
  logic w_out_last;

  // Grant and pop are combinational so a grant in cycle N pops in N+1;
  // both are held off while reset is asserted.
  assign burst_gnt_o = ~rst & burst_req_i & (r_state == IDLE);
  assign w_pop_fifo  = ~rst & fifo_rd_ready_i & (r_state == BURST) &
                       (r_pop_cnt < LEN) & ~w_full;
  assign w_accept    = ~w_empty & dq_ready_i;
  assign w_out_last  = (r_out_cnt == LAST);

  assign fifo_rd_o   = w_pop_fifo;
  assign dq_valid_o  = ~w_empty;
  assign dq_last_o   = ~w_empty & w_out_last;
  assign busy_o      = (r_state != IDLE);
  assign underrun_o  = r_underrun;
  assign burst_cnt_o = r_burst_cnt;

  skid_buf2 #(.W(DDR_DATA_W)) u_buf (
    .i_clk   (clk_i),
    .i_rst   (rst),
    .i_push  (w_pop_fifo),
    .i_data  (fifo_data_i),
    .i_pop   (w_accept),
    .o_data  (dq_data_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pop_cnt   <= '0;
      r_out_cnt   <= '0;
      r_stall_cnt <= '0;
      r_underrun  <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_underrun <= 1'b0;
      if (w_accept) begin
        r_out_cnt <= r_out_cnt + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (burst_req_i) begin
            r_state     <= BURST;
            r_pop_cnt   <= '0;
            r_out_cnt   <= '0;
            r_stall_cnt <= '0;
          end
        end
        BURST: begin
          // Only an empty FIFO counts as a stall; a full output buffer does not.
          if (w_pop_fifo) begin
            r_pop_cnt   <= r_pop_cnt + 1'b1;
            r_stall_cnt <= '0;
            if (r_pop_cnt == LAST) begin
              r_state <= FLUSH;
            end
          end else if (!fifo_rd_ready_i && (r_pop_cnt < LEN)) begin
            if (r_stall_cnt == STALL_LAST) begin
              r_stall_cnt <= '0;
              r_underrun  <= 1'b1;
            end else begin
              r_stall_cnt <= r_stall_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (w_accept && w_out_last) begin
            r_state     <= IDLE;
            r_burst_cnt <= r_burst_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
